// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// Tuse/Tnew encodings, mult/div latency defaults and the busy-timer state type.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_NOW  = 2'd0;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned BUSY_W_MIN      = 4;

  typedef enum logic {StIdle, StBusy} mdu_state_e;

  // Smallest counter width (never below BUSY_W_MIN) that can hold max_cycles.
  function automatic int unsigned busy_cnt_width(input int unsigned max_cycles);
    int unsigned w;
    w = BUSY_W_MIN;
    while ((64'd1 << w) <= 64'(max_cycles)) w++;
    return w;
  endfunction

endpackage

// File: rtl/mdu_busy_timer.sv
// Mult/div busy timer: loads the op latency on a start, counts down to idle.
// o_busy is high for exactly the loaded number of cycles after the start cycle.
module mdu_busy_timer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  localparam int unsigned BusyW =
      busy_cnt_width((DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES);

  mdu_state_e       r_state, w_state_next;
  logic [BusyW-1:0] r_cnt, w_cnt_next, w_load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // A start always reloads, even mid-operation: the newest op wins.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = i_is_div ? BusyW'(DIV_CYCLES) : BusyW'(MULT_CYCLES);
    if (i_start) begin
      w_cnt_next   = w_load;
      w_state_next = (w_load != '0) ? StBusy : StIdle;
    end else if (r_state == StBusy) begin
      w_cnt_next = r_cnt - BusyW'(1);
      if (r_cnt == BusyW'(1)) w_state_next = StIdle;
    end
  end

  always_comb begin
    o_busy = (r_state == StBusy);
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller: Tuse/Tnew data-hazard check plus mult/div
// busy interlock, driving PCEN, the D-register enable and the E-register flush.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs_addr,
  input  logic [4:0]       d_rt_addr,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_wr_addr,
  input  logic [1:0]       e_tnew,
  input  logic             e_md_start,
  input  logic             e_is_div,
  input  logic [4:0]       m_wr_addr,
  input  logic [1:0]       m_tnew,
  output logic             PCEN,
  output logic             d_en,
  output logic             e_flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             w_hz_rs, w_hz_rt, w_hz_md, w_stall, w_timer_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  mdu_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_mdu_busy_timer (
    .clk      (clk),
    .reset    (reset),
    .i_start  (e_md_start),
    .i_is_div (e_is_div),
    .o_busy   (w_timer_busy)
  );

  // TUSE_NONE (3) can never be below a 2-bit Tnew, so it needs no special case.
  always_comb begin
    w_hz_rs = (d_rs_addr != 5'd0) &&
              (((d_rs_addr == e_wr_addr) && (d_tuse_rs < e_tnew)) ||
               ((d_rs_addr == m_wr_addr) && (d_tuse_rs < m_tnew)));
    w_hz_rt = (d_rt_addr != 5'd0) &&
              (((d_rt_addr == e_wr_addr) && (d_tuse_rt < e_tnew)) ||
               ((d_rt_addr == m_wr_addr) && (d_tuse_rt < m_tnew)));
    w_hz_md = d_is_md && (w_timer_busy || e_md_start);
    w_stall = w_hz_rs || w_hz_rt || w_hz_md;
  end

  // Reset overrides everything so the pipeline free-runs while held.
  always_comb begin
    PCEN     = !reset || !w_stall;
    d_en     = !reset || !w_stall;
    e_flush  = reset && w_stall;
    mdu_busy = reset && w_timer_busy;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
